// File: rtl/add_sub_rs_pkg.sv
// add_sub_rs_pkg: shared op encoding and default tag width for the add/sub reservation station.
package add_sub_rs_pkg;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_t;

    localparam int TAG_W_DEF = 4;

endpackage

// File: rtl/add_sub_rs_if.sv
// add_sub_rs_if: dispatch, CDB snoop and issue handshake bundle of the add/sub reservation station.
interface add_sub_rs_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
);
    import add_sub_rs_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic             disp_valid;
    logic             disp_ready;
    op_t              disp_op;
    logic [TAG_W-1:0] disp_tag;
    logic             disp_rj;
    logic [WIDTH-1:0] disp_vj;
    logic [TAG_W-1:0] disp_qj;
    logic             disp_rk;
    logic [WIDTH-1:0] disp_vk;
    logic [TAG_W-1:0] disp_qk;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [WIDTH-1:0] cdb_data;
    logic             ex_valid;
    logic             ex_ready;
    op_t              ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [TAG_W-1:0] ex_tag;
    logic [CW-1:0]    count;

    modport master (
        output disp_valid, disp_op, disp_tag, disp_rj, disp_vj, disp_qj, disp_rk, disp_vk, disp_qk,
        output cdb_valid, cdb_tag, cdb_data, ex_ready,
        input  disp_ready, ex_valid, ex_op, ex_a, ex_b, ex_tag, count
    );

    modport slave (
        input  disp_valid, disp_op, disp_tag, disp_rj, disp_vj, disp_qj, disp_rk, disp_vk, disp_qk,
        input  cdb_valid, cdb_tag, cdb_data, ex_ready,
        output disp_ready, ex_valid, ex_op, ex_a, ex_b, ex_tag, count
    );

endinterface

// File: rtl/add_sub_rs_entry.sv
// add_sub_rs_entry: one reservation station slot with dispatch-time bypass and CDB wakeup.
module add_sub_rs_entry
    import add_sub_rs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr,
    input  logic             clr,
    input  op_t              d_op,
    input  logic [TAG_W-1:0] d_tag,
    input  logic             d_rj,
    input  logic [WIDTH-1:0] d_vj,
    input  logic [TAG_W-1:0] d_qj,
    input  logic             d_rk,
    input  logic [WIDTH-1:0] d_vk,
    input  logic [TAG_W-1:0] d_qk,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [WIDTH-1:0] cdb_data,
    output logic             busy,
    output logic             ready,
    output op_t              op,
    output logic [TAG_W-1:0] tag,
    output logic [WIDTH-1:0] vj,
    output logic [WIDTH-1:0] vk
);

    logic             rj, rk, hit_j, hit_k;
    logic [TAG_W-1:0] qj, qk;

    // On a write the incoming producer tags are snooped, otherwise the stored ones
    assign hit_j = cdb_valid && cdb_tag != '0 && cdb_tag == (wr ? d_qj : qj);
    assign hit_k = cdb_valid && cdb_tag != '0 && cdb_tag == (wr ? d_qk : qk);
    assign ready = busy && rj && rk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            op   <= OP_ADD;
            tag  <= '0;
            rj   <= 1'b0;
            vj   <= '0;
            qj   <= '0;
            rk   <= 1'b0;
            vk   <= '0;
            qk   <= '0;
        end else if (flush) begin
            busy <= 1'b0;
        end else if (wr) begin
            busy <= 1'b1;
            op   <= d_op;
            tag  <= d_tag;
            rj   <= d_rj || hit_j;
            vj   <= (!d_rj && hit_j) ? cdb_data : d_vj;
            qj   <= d_qj;
            rk   <= d_rk || hit_k;
            vk   <= (!d_rk && hit_k) ? cdb_data : d_vk;
            qk   <= d_qk;
        end else begin
            if (clr) busy <= 1'b0;
            if (busy && !rj && hit_j) begin
                rj <= 1'b1;
                vj <= cdb_data;
            end
            if (busy && !rk && hit_k) begin
                rk <= 1'b1;
                vk <= cdb_data;
            end
        end
    end

endmodule

// File: rtl/add_sub_rs.sv
// add_sub_rs: add/sub reservation station; fills the lowest free slot and issues the lowest ready one.
module add_sub_rs
    import add_sub_rs_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = TAG_W_DEF,
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst_n,
    input logic        flush,
    add_sub_rs_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] busy, ready, wr, iss;
    op_t              op  [DEPTH];
    logic [TAG_W-1:0] tag [DEPTH];
    logic [WIDTH-1:0] vj  [DEPTH];
    logic [WIDTH-1:0] vk  [DEPTH];
    op_t              ex_op;
    logic [WIDTH-1:0] ex_a, ex_b;
    logic [TAG_W-1:0] ex_tag;
    logic [CW-1:0]    cnt;

    // Isolate the lowest zero of busy and the lowest one of ready
    assign bus.disp_ready = ~&busy;
    assign wr  = (bus.disp_valid && bus.disp_ready) ? (~busy & (busy + DEPTH'(1))) : '0;
    assign iss = ready & (~ready + DEPTH'(1));

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        add_sub_rs_entry #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_ent (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .wr       (wr[i]),
            .clr      (iss[i] && bus.ex_ready),
            .d_op     (bus.disp_op),
            .d_tag    (bus.disp_tag),
            .d_rj     (bus.disp_rj),
            .d_vj     (bus.disp_vj),
            .d_qj     (bus.disp_qj),
            .d_rk     (bus.disp_rk),
            .d_vk     (bus.disp_vk),
            .d_qk     (bus.disp_qk),
            .cdb_valid(bus.cdb_valid),
            .cdb_tag  (bus.cdb_tag),
            .cdb_data (bus.cdb_data),
            .busy     (busy[i]),
            .ready    (ready[i]),
            .op       (op[i]),
            .tag      (tag[i]),
            .vj       (vj[i]),
            .vk       (vk[i])
        );
    end

    always_comb begin
        ex_op  = OP_ADD;
        ex_a   = '0;
        ex_b   = '0;
        ex_tag = '0;
        cnt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss[i]) begin
                ex_op  = op[i];
                ex_a   = vj[i];
                ex_b   = vk[i];
                ex_tag = tag[i];
            end
            cnt = cnt + CW'(busy[i]);
        end
    end

    assign bus.ex_valid = |ready;
    assign bus.ex_op    = ex_op;
    assign bus.ex_a     = ex_a;
    assign bus.ex_b     = ex_b;
    assign bus.ex_tag   = ex_tag;
    assign bus.count    = cnt;

endmodule

// File: tb/tb_add_sub_rs.sv
// tb_add_sub_rs: directed scenarios plus a randomized run against a slot-level reference model.
module tb_add_sub_rs;
    import add_sub_rs_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;

    add_sub_rs_if #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) bus ();

    add_sub_rs #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic idle();
        flush = 1'b0;
        bus.disp_valid = 1'b0;
        bus.disp_op = OP_ADD;
        bus.disp_tag = '0;
        bus.disp_rj = 1'b1;
        bus.disp_vj = '0;
        bus.disp_qj = '0;
        bus.disp_rk = 1'b1;
        bus.disp_vk = '0;
        bus.disp_qk = '0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0;
        bus.cdb_data = '0;
        bus.ex_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input op_t op, input logic [TAG_W-1:0] tag, input logic rj,
                        input logic [WIDTH-1:0] vj, input logic [TAG_W-1:0] qj, input logic rk,
                        input logic [WIDTH-1:0] vk, input logic [TAG_W-1:0] qk);
        bus.disp_valid = 1'b1;
        bus.disp_op = op;
        bus.disp_tag = tag;
        bus.disp_rj = rj;
        bus.disp_vj = vj;
        bus.disp_qj = qj;
        bus.disp_rk = rk;
        bus.disp_vk = vk;
        bus.disp_qk = qk;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = tag;
        bus.cdb_data = data;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0b exp=0", bus.ex_valid); end
        checks++; if (bus.disp_ready !== 1'b1) begin failures++; $display("FAIL reset_disp_ready got=%0b exp=1", bus.disp_ready); end
        checks++; if (bus.count !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.ex_a !== 0 || bus.ex_b !== 0 || bus.ex_tag !== 0) begin failures++; $display("FAIL reset_ex_data got=%0h/%0h/%0h exp=0", bus.ex_a, bus.ex_b, bus.ex_tag); end
        rst_n = 1'b1;
        tick();
        disp(OP_ADD, 4'd1, 1'b1, 32'd1, '0, 1'b1, 32'd2, '0);
        tick();
        disp(OP_SUB, 4'd2, 1'b1, 32'd3, '0, 1'b1, 32'd4, '0);
        tick();
        idle();
        checks++; if (bus.count !== 2) begin failures++; $display("FAIL mid_count got=%0d exp=2", bus.count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL async_reset_ex_valid got=%0b exp=0", bus.ex_valid); end
        checks++; if (bus.disp_ready !== 1'b1) begin failures++; $display("FAIL async_reset_disp_ready got=%0b exp=1", bus.disp_ready); end
        checks++; if (bus.count !== 0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", bus.count); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ready_dispatch();
        idle();
        bus.ex_ready = 1'b1;
        disp(OP_ADD, 4'd2, 1'b1, 32'd5, '0, 1'b1, 32'd3, '0);
        tick();
        idle();
        bus.ex_ready = 1'b1;
        checks++; if (bus.count !== 1) begin failures++; $display("FAIL rd_count got=%0d exp=1", bus.count); end
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL rd_ex_valid got=%0b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_a !== 32'd5 || bus.ex_b !== 32'd3) begin failures++; $display("FAIL rd_operands got=%0d/%0d exp=5/3", bus.ex_a, bus.ex_b); end
        checks++; if (bus.ex_op !== OP_ADD || bus.ex_tag !== 4'd2) begin failures++; $display("FAIL rd_op_tag got=%0b/%0d exp=0/2", bus.ex_op, bus.ex_tag); end
        tick();
        checks++; if (bus.count !== 0 || bus.ex_valid !== 1'b0) begin failures++; $display("FAIL rd_drain got count=%0d ex_valid=%0b exp=0/0", bus.count, bus.ex_valid); end
    endtask

    task automatic test_wakeup();
        idle();
        bus.ex_ready = 1'b1;
        disp(OP_SUB, 4'd3, 1'b0, 32'd0, 4'd7, 1'b1, 32'd10, '0);
        tick();
        idle();
        bus.ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL wk_wait%0d got=%0b exp=0", i, bus.ex_valid); end
            if (i == 2) cdb(4'd7, 32'd25);
            tick();
        end
        idle();
        bus.ex_ready = 1'b1;
        checks++; if (bus.ex_valid !== 1'b1) begin failures++; $display("FAIL wk_ex_valid got=%0b exp=1", bus.ex_valid); end
        checks++; if (bus.ex_a !== 32'd25 || bus.ex_b !== 32'd10) begin failures++; $display("FAIL wk_operands got=%0d/%0d exp=25/10", bus.ex_a, bus.ex_b); end
        checks++; if (bus.ex_op !== OP_SUB || bus.ex_tag !== 4'd3) begin failures++; $display("FAIL wk_op_tag got=%0b/%0d exp=1/3", bus.ex_op, bus.ex_tag); end
        tick();
        checks++; if (bus.count !== 0) begin failures++; $display("FAIL wk_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_null_tag();
        idle();
        bus.ex_ready = 1'b1;
        disp(OP_ADD, 4'd4, 1'b0, 32'd0, 4'd0, 1'b1, 32'd1, '0);
        cdb(4'd0, 32'd77);
        tick();
        idle();
        bus.ex_ready = 1'b1;
        cdb(4'd0, 32'd78);
        tick();
        idle();
        checks++; if (bus.ex_valid !== 1'b0 || bus.count !== 1) begin failures++; $display("FAIL null_tag got ex_valid=%0b count=%0d exp=0/1", bus.ex_valid, bus.count); end
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = 4'd5;
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL cdb_invalid got=%0b exp=0", bus.ex_valid); end
        flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        idle();
        bus.ex_ready = 1'b1;
        disp(OP_ADD, 4'd5, 1'b0, 32'd0, 4'd4, 1'b1, 32'd1, '0);
        cdb(4'd4, 32'd9);
        tick();
        idle();
        bus.ex_ready = 1'b1;
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'd9) begin failures++; $display("FAIL bp_single got ex_valid=%0b a=%0d exp=1/9", bus.ex_valid, bus.ex_a); end
        disp(OP_SUB, 4'd6, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd6);
        cdb(4'd6, 32'd11);
        tick();
        idle();
        bus.ex_ready = 1'b1;
        checks++; if (bus.count !== 1) begin failures++; $display("FAIL bp_issue_disp_count got=%0d exp=1", bus.count); end
        checks++; if (bus.ex_a !== 32'd11 || bus.ex_b !== 32'd11 || bus.ex_tag !== 4'd6) begin failures++; $display("FAIL bp_dual got=%0d/%0d/%0d exp=11/11/6", bus.ex_a, bus.ex_b, bus.ex_tag); end
        tick();
        checks++; if (bus.count !== 0) begin failures++; $display("FAIL bp_drain got=%0d exp=0", bus.count); end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] order [DEPTH];
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            disp(OP_ADD, TAG_W'(i + 1), 1'b1, WIDTH'(100 + i), '0, 1'b1, WIDTH'(i), '0);
            tick();
        end
        idle();
        checks++; if (bus.disp_ready !== 1'b0 || bus.count !== DEPTH) begin failures++; $display("FAIL full got disp_ready=%0b count=%0d exp=0/%0d", bus.disp_ready, bus.count, DEPTH); end
        checks++; if (bus.ex_a !== 32'd100) begin failures++; $display("FAIL full_lowest got=%0d exp=100", bus.ex_a); end
        disp(OP_ADD, 4'd9, 1'b1, 32'd999, '0, 1'b1, 32'd0, '0);
        tick();
        checks++; if (bus.count !== DEPTH || bus.ex_a !== 32'd100) begin failures++; $display("FAIL full_ignore got count=%0d a=%0d exp=%0d/100", bus.count, bus.ex_a, DEPTH); end
        disp(OP_ADD, 4'd10, 1'b1, 32'd200, '0, 1'b1, 32'd0, '0);
        bus.ex_ready = 1'b1;
        tick();
        idle();
        checks++; if (bus.count !== DEPTH - 1 || bus.disp_ready !== 1'b1) begin failures++; $display("FAIL full_issue got count=%0d disp_ready=%0b exp=%0d/1", bus.count, bus.disp_ready, DEPTH - 1); end
        checks++; if (bus.ex_a !== 32'd101) begin failures++; $display("FAIL full_next got=%0d exp=101", bus.ex_a); end
        disp(OP_ADD, 4'd11, 1'b1, 32'd300, '0, 1'b1, 32'd0, '0);
        tick();
        idle();
        checks++; if (bus.count !== DEPTH || bus.ex_a !== 32'd300) begin failures++; $display("FAIL full_refill got count=%0d a=%0d exp=%0d/300", bus.count, bus.ex_a, DEPTH); end
        order[0] = 32'd300;
        for (int i = 1; i < DEPTH; i++) order[i] = WIDTH'(100 + i);
        bus.ex_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== order[i]) begin failures++; $display("FAIL drain_order%0d got=%0d exp=%0d", i, bus.ex_a, order[i]); end
            tick();
        end
        idle();
        checks++; if (bus.count !== 0) begin failures++; $display("FAIL full_drained got=%0d exp=0", bus.count); end
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) begin
            disp(OP_SUB, TAG_W'(i + 1), 1'b1, WIDTH'(i), '0, 1'b1, WIDTH'(i), '0);
            tick();
        end
        idle();
        checks++; if (bus.count !== 3) begin failures++; $display("FAIL fl_pre got=%0d exp=3", bus.count); end
        flush = 1'b1;
        bus.ex_ready = 1'b1;
        disp(OP_ADD, 4'd8, 1'b1, 32'd1, '0, 1'b1, 32'd1, '0);
        cdb(4'd3, 32'd5);
        tick();
        idle();
        checks++; if (bus.count !== 0 || bus.ex_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin failures++; $display("FAIL fl_post got count=%0d ex_valid=%0b disp_ready=%0b exp=0/0/1", bus.count, bus.ex_valid, bus.disp_ready); end
        tick();
        checks++; if (bus.count !== 0) begin failures++; $display("FAIL fl_no_disp got=%0d exp=0", bus.count); end
    endtask

    task automatic test_random();
        logic             m_busy [DEPTH];
        op_t              m_op   [DEPTH];
        logic [TAG_W-1:0] m_tag  [DEPTH];
        logic             m_rj   [DEPTH];
        logic [WIDTH-1:0] m_vj   [DEPTH];
        logic [TAG_W-1:0] m_qj   [DEPTH];
        logic             m_rk   [DEPTH];
        logic [WIDTH-1:0] m_vk   [DEPTH];
        logic [TAG_W-1:0] m_qk   [DEPTH];
        int sel, fs, nfree;
        logic hj, hk;
        idle();
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            sel = -1;
            fs = -1;
            nfree = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && m_rj[i] && m_rk[i] && sel < 0) sel = i;
                if (!m_busy[i] && fs < 0) fs = i;
                if (!m_busy[i]) nfree++;
            end
            checks++; if (bus.ex_valid !== (sel >= 0)) begin failures++; $display("FAIL rnd_ex_valid c=%0d got=%0b exp=%0b", c, bus.ex_valid, sel >= 0); end
            checks++; if (bus.disp_ready !== (nfree > 0)) begin failures++; $display("FAIL rnd_disp_ready c=%0d got=%0b exp=%0b", c, bus.disp_ready, nfree > 0); end
            checks++; if (bus.count !== DEPTH - nfree) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.count, DEPTH - nfree); end
            if (sel >= 0) begin
                checks++; if (bus.ex_a !== m_vj[sel] || bus.ex_b !== m_vk[sel] || bus.ex_op !== m_op[sel] || bus.ex_tag !== m_tag[sel]) begin failures++; $display("FAIL rnd_issue c=%0d got=%0h/%0h/%0b/%0d exp=%0h/%0h/%0b/%0d", c, bus.ex_a, bus.ex_b, bus.ex_op, bus.ex_tag, m_vj[sel], m_vk[sel], m_op[sel], m_tag[sel]); end
            end
            flush = ($urandom_range(0, 39) == 0);
            bus.disp_valid = $urandom_range(0, 1) == 1;
            bus.disp_op = op_t'($urandom_range(0, 1));
            bus.disp_tag = TAG_W'($urandom_range(1, 15));
            bus.disp_rj = $urandom_range(0, 2) != 0;
            bus.disp_vj = $urandom;
            bus.disp_qj = TAG_W'($urandom_range(0, 3));
            bus.disp_rk = $urandom_range(0, 2) != 0;
            bus.disp_vk = $urandom;
            bus.disp_qk = TAG_W'($urandom_range(0, 3));
            bus.cdb_valid = $urandom_range(0, 1) == 1;
            bus.cdb_tag = TAG_W'($urandom_range(0, 3));
            bus.cdb_data = $urandom;
            bus.ex_ready = $urandom_range(0, 2) != 0;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else begin
                if (sel >= 0 && bus.ex_ready) m_busy[sel] = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_busy[i] && bus.cdb_valid && bus.cdb_tag != 0) begin
                        if (!m_rj[i] && m_qj[i] == bus.cdb_tag) begin m_rj[i] = 1'b1; m_vj[i] = bus.cdb_data; end
                        if (!m_rk[i] && m_qk[i] == bus.cdb_tag) begin m_rk[i] = 1'b1; m_vk[i] = bus.cdb_data; end
                    end
                end
                if (bus.disp_valid && fs >= 0) begin
                    hj = bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == bus.disp_qj && !bus.disp_rj;
                    hk = bus.cdb_valid && bus.cdb_tag != 0 && bus.cdb_tag == bus.disp_qk && !bus.disp_rk;
                    m_busy[fs] = 1'b1;
                    m_op[fs] = bus.disp_op;
                    m_tag[fs] = bus.disp_tag;
                    m_rj[fs] = bus.disp_rj || hj;
                    m_vj[fs] = hj ? bus.cdb_data : bus.disp_vj;
                    m_qj[fs] = bus.disp_qj;
                    m_rk[fs] = bus.disp_rk || hk;
                    m_vk[fs] = hk ? bus.cdb_data : bus.disp_vk;
                    m_qk[fs] = bus.disp_qk;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_null_tag();
        test_bypass();
        test_full();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
